// File: rtl/slsr_pkg.sv
// ----------------------------------------------------------------------------
// slsr_pkg
// Shared definitions for the slsr serial link (transmitter and receiver side).
//   tx_state_e : transmitter FSM state encoding
//   cnt_w()    : width of a counter able to hold the bit index 0..w-1
// ----------------------------------------------------------------------------
package slsr_pkg;

  typedef enum logic {
    TX_IDLE  = 1'b0,
    TX_SHIFT = 1'b1
  } tx_state_e;

  // Bits needed to count down from w-1 to 0.
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/slsr_bit_cnt.sv
// ----------------------------------------------------------------------------
// slsr_bit_cnt
// Loadable down-counter used as the transmitter bit index.
// Ports:
//   clk      in  1   clock, all updates on posedge
//   reset    in  1   synchronous active-high reset (count -> 0)
//   load     in  1   load load_val (has priority over en)
//   load_val in  CW  value to load
//   en       in  1   decrement by one
//   is_zero  out 1   count equals zero
// ----------------------------------------------------------------------------
module slsr_bit_cnt
  import slsr_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CW = cnt_w(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          is_zero
);

  logic [CW-1:0] cnt_r;

  // Bit index register: load wins over decrement, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CW{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en) begin
      cnt_r <= cnt_r - CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign is_zero = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/slsr_tx.sv
// ----------------------------------------------------------------------------
// slsr_tx
// Parallel-in/serial-out transmitter for the slsr shift receiver. A WIDTH-bit
// word is taken on a valid/ready handshake and sent one bit per clock on dout,
// with sl (LSB-first) or sr (MSB-first) strobing the receiver so that its Q
// equals the word after WIDTH shifts.
// Optional build macro: SLSR_TX_HOLD_EN adds the 'hold' input that pauses the
// shift (no strobe, state frozen) while high.
// Ports:
//   clk        in  1      clock
//   reset      in  1      synchronous active-high reset
//   data_in    in  WIDTH  word, sampled on load handshake
//   msb_first  in  1      1 = MSB first (sr), 0 = LSB first (sl)
//   load_valid in  1      producer offers a word
//   load_ready out 1      idle and not in reset
//   hold       in  1      (SLSR_TX_HOLD_EN only) pause shifting
//   dout       out 1      serial bit (registered)
//   sl         out 1      receiver strobe, shift in at MSB (registered)
//   sr         out 1      receiver strobe, shift in at LSB (registered)
//   busy       out 1      high while shifting (registered)
//   done       out 1      one-cycle pulse after the last bit (registered)
// ----------------------------------------------------------------------------
module slsr_tx
  import slsr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             msb_first,
  input  logic             load_valid,
  output logic             load_ready,
`ifdef SLSR_TX_HOLD_EN
  input  logic             hold,
`endif
  output logic             dout,
  output logic             sl,
  output logic             sr,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_w(WIDTH);

  tx_state_e        state_r;
  logic [WIDTH-1:0] shreg_r;
  logic             dir_r;
  logic             hold_s;
  logic             accept_s;
  logic             shift_s;
  logic             cnt_zero_s;

`ifdef SLSR_TX_HOLD_EN
  assign hold_s = hold;
`else
  assign hold_s = 1'b0;
`endif

  assign load_ready = (state_r == TX_IDLE) && !reset;

  // Handshake and shift-enable decode; hold only matters while shifting.
  always_comb begin
    accept_s = load_valid && load_ready;
    shift_s  = (state_r == TX_SHIFT) && !hold_s;
  end

  slsr_bit_cnt #(
    .WIDTH (WIDTH)
  ) u_bit_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (accept_s),
    .load_val (CW'(WIDTH - 1)),
    .en       (shift_s && !cnt_zero_s),
    .is_zero  (cnt_zero_s)
  );

  // FSM, word capture and registered serial outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= TX_IDLE;
      shreg_r <= {WIDTH{1'b0}};
      dir_r   <= 1'b0;
      dout    <= 1'b0;
      sl      <= 1'b0;
      sr      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        TX_IDLE: begin
          done <= 1'b0;
          if (accept_s) begin
            // Bit 0 of the stream is presented straight from data_in so it
            // appears in the cycle right after acceptance.
            shreg_r <= data_in;
            dir_r   <= msb_first;
            dout    <= msb_first ? data_in[WIDTH-1] : data_in[0];
            sl      <= !msb_first;
            sr      <= msb_first;
            busy    <= 1'b1;
            state_r <= TX_SHIFT;
          end else begin
            dout    <= 1'b0;
            sl      <= 1'b0;
            sr      <= 1'b0;
            busy    <= 1'b0;
            state_r <= TX_IDLE;
          end
        end
        TX_SHIFT: begin
          if (hold_s) begin
            // Frozen: dout keeps the pending bit, receiver is not strobed.
            sl   <= 1'b0;
            sr   <= 1'b0;
            done <= 1'b0;
          end else if (cnt_zero_s) begin
            state_r <= TX_IDLE;
            dout    <= 1'b0;
            sl      <= 1'b0;
            sr      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            // shreg moves the presented bit out; the next one sits adjacent.
            if (dir_r) begin
              shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
              dout    <= shreg_r[WIDTH-2];
            end else begin
              shreg_r <= {1'b0, shreg_r[WIDTH-1:1]};
              dout    <= shreg_r[1];
            end
            sl   <= !dir_r;
            sr   <= dir_r;
            done <= 1'b0;
          end
        end
        default: begin
          state_r <= TX_IDLE;
          dout    <= 1'b0;
          sl      <= 1'b0;
          sr      <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slsr_tx.sv
// ----------------------------------------------------------------------------
// tb_slsr_tx
// Self-checking bench for slsr_tx. A behavioural slsr receiver is driven from
// dout/sl/sr. Every accepted word pushes its expected bit stream and final
// word onto scoreboard queues; a negedge monitor pops and compares them.
// ----------------------------------------------------------------------------
module tb_slsr_tx;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] word;
    int           lat;
    int           acc;
  } word_t;

  logic         clk;
  logic         reset;
  logic [W-1:0] data_in;
  logic         msb_first;
  logic         load_valid;
  logic         load_ready;
  logic         hold;
  logic         dout;
  logic         sl;
  logic         sr;
  logic         busy;
  logic         done;

  logic [W-1:0] rx_q;
  int           cyc;
  int           chk_cnt;
  int           err_cnt;

  logic  exp_bit_q[$];
  logic  exp_dir_q[$];
  word_t word_q[$];

  slsr_tx #(
    .WIDTH (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .msb_first  (msb_first),
    .load_valid (load_valid),
    .load_ready (load_ready),
`ifdef SLSR_TX_HOLD_EN
    .hold       (hold),
`endif
    .dout       (dout),
    .sl         (sl),
    .sr         (sr),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter: value after an edge = number of edges seen.
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver: sl shifts din in at the MSB, sr at the LSB.
  always @(posedge clk) begin
    if (sl)      rx_q <= {dout, rx_q[W-1:1]};
    else if (sr) rx_q <= {rx_q[W-2:0], dout};
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      check_eq("no_double_strobe", {31'd0, sl && sr}, 32'd0);
      if (sl || sr) begin
        check_eq("busy_while_shift", {31'd0, busy}, 32'd1);
        if (exp_bit_q.size() == 0) begin
          check_eq("unexpected_strobe", {31'd0, sl || sr}, 32'd0);
        end else begin
          check_eq("dout_bit", {31'd0, dout}, {31'd0, exp_bit_q.pop_front()});
          check_eq("strobe_dir", {31'd0, sr}, {31'd0, exp_dir_q.pop_front()});
        end
      end else if (!busy) begin
        check_eq("idle_dout_zero", {31'd0, dout}, 32'd0);
      end
      if (done) begin
        check_eq("busy_low_at_done", {31'd0, busy}, 32'd0);
        check_eq("ready_at_done", {31'd0, load_ready}, 32'd1);
        if (word_q.size() == 0) begin
          check_eq("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          word_t e;
          e = word_q.pop_front();
          check_eq("rx_word", {24'd0, rx_q}, {24'd0, e.word});
          check_eq("done_latency", cyc - e.acc, e.lat);
        end
      end
    end
  end

  // Offer a word, wait (bounded) for acceptance, push expectations.
  task automatic send(input logic [W-1:0] w, input logic msb, input int holds, output int acc);
    int n;
    word_t e;
    data_in    = w;
    msb_first  = msb;
    load_valid = 1'b1;
    n = 0;
    while (!load_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("ready_in_time", {31'd0, load_ready}, 32'd1);
    for (int i = 0; i < W; i++) begin
      exp_bit_q.push_back(msb ? w[W-1-i] : w[i]);
      exp_dir_q.push_back(msb);
    end
    @(posedge clk); #1;
    acc = cyc;
    // done appears WIDTH cycles after the cycle holding bit 0, plus holds
    e.word = w; e.lat = W + holds; e.acc = acc;
    word_q.push_back(e);
    load_valid = 1'b0;
    data_in    = ~w;
    msb_first  = ~msb;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (word_q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain_words", word_q.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    int a1;
    int a2;
    cyc = 0; chk_cnt = 0; err_cnt = 0; rx_q = '0;
    reset = 1'b1; data_in = '0; msb_first = 1'b0; load_valid = 1'b0; hold = 1'b0;

    // 1. reset held 3 cycles
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_dout", {31'd0, dout}, 32'd0);
    check_eq("rst_sl_sr", {30'd0, sl, sr}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_ready_low", {31'd0, load_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check_eq("ready_after_rst", {31'd0, load_ready}, 32'd1);
    @(posedge clk); #1;

    // 2. LSB first
    send(8'hA5, 1'b0, 0, a1);
    check_eq("busy_after_load", {31'd0, busy}, 32'd1);
    check_eq("ready_low_shift", {31'd0, load_ready}, 32'd0);
    drain();

    // 3. MSB first
    send(8'h3C, 1'b1, 0, a1);
    drain();

    // 4. second word offered during shift waits for the done cycle
    send(8'hFF, 1'b1, 0, a1);
    send(8'h00, 1'b0, 0, a2);
    check_eq("back_to_back_period", a2 - a1, W + 1);
    drain();

    // 5. reset at bit 3 aborts the word
    send(8'h81, 1'b0, 0, a1);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_dout", {31'd0, dout}, 32'd0);
    check_eq("abort_sl_sr", {30'd0, sl, sr}, 32'd0);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_done", {31'd0, done}, 32'd0);
    exp_bit_q.delete();
    exp_dir_q.delete();
    word_q.delete();
    reset = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    send(8'h42, 1'b0, 0, a1);
    drain();

`ifdef SLSR_TX_HOLD_EN
    // 6. hold for 4 cycles after bit 2
    send(8'hC3, 1'b0, 4, a1);
    repeat (2) begin @(posedge clk); #1; end
    hold = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check_eq("hold_no_strobe", {30'd0, sl, sr}, 32'd0);
    end
    hold = 1'b0;
    drain();
`endif

    check_eq("bits_consumed", exp_bit_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, err_cnt);
    $finish;
  end

endmodule
